// File: rtl/unidad_division_iterativa_if.sv
// Divider request/result bundle between the EXE issue stage and the divider.
// DIV_REMAINDER_EN adds rem_sel (latched with start, selects remainder on div_DI).
interface unidad_division_iterativa_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
);
  logic             start;
  logic             flush;
  logic [RD_W-1:0]  Rd;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_REMAINDER_EN
  logic             rem_sel;
`endif
  logic             busy;
  logic             div_valid;
  logic [RD_W-1:0]  div_Rd;
  logic [WIDTH-1:0] div_DI;

  modport master (
    output start, flush, Rd, dividend, divisor,
`ifdef DIV_REMAINDER_EN
    output rem_sel,
`endif
    input  busy, div_valid, div_Rd, div_DI
  );

  modport slave (
    input  start, flush, Rd, dividend, divisor,
`ifdef DIV_REMAINDER_EN
    input  rem_sel,
`endif
    output busy, div_valid, div_Rd, div_DI
  );
endinterface

// File: rtl/unidad_division_iterativa.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional DIV_REMAINDER_EN: rem_sel selects the remainder as the result.
module unidad_division_iterativa #(
  parameter int              WIDTH   = 32,
  parameter int              RD_W    = 4,
  parameter logic [RD_W-1:0] NULL_RD = '0
) (
  input logic clk,
  input logic rst,
  unidad_division_iterativa_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quot, r_dvs;
  logic [RD_W-1:0]  r_rd;
  logic             r_dz;
  logic             w_accept;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_res;
`ifdef DIV_REMAINDER_EN
  logic             r_rem_sel;
`endif

  assign w_accept = bus.start & ~bus.flush & (r_state != BUSY);
  assign w_rem_sh = {r_rem, r_quot[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    w_next = bus.start ? BUSY : IDLE;
        BUSY:    if (r_cnt == CW'(1)) w_next = DONE;
        DONE:    w_next = bus.start ? BUSY : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Divide by zero takes a single BUSY cycle that loads the all-ones quotient
  // and the dividend as remainder, matching what the full iteration would give.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_rd   <= NULL_RD;
      r_dz   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_rem_sel <= 1'b0;
`endif
    end else if (w_accept) begin
      r_rd   <= bus.Rd;
      r_dvs  <= bus.divisor;
      r_dz   <= (bus.divisor == '0);
      r_rem  <= '0;
      r_quot <= bus.dividend;
      r_cnt  <= (bus.divisor == '0) ? CW'(1) : CW'(WIDTH);
`ifdef DIV_REMAINDER_EN
      r_rem_sel <= bus.rem_sel;
`endif
    end else if (r_state == BUSY && !bus.flush) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_dz) begin
        r_rem  <= r_quot;
        r_quot <= '1;
      end else if (!w_diff[WIDTH]) begin
        r_rem  <= w_diff[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], 1'b1};
      end else begin
        r_rem  <= w_rem_sh[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef DIV_REMAINDER_EN
  assign w_res = r_rem_sel ? r_rem : r_quot;
`else
  assign w_res = r_quot;
`endif

  assign bus.busy      = (r_state == BUSY);
  assign bus.div_valid = (r_state == DONE);
  assign bus.div_Rd    = bus.div_valid ? r_rd  : NULL_RD;
  assign bus.div_DI    = bus.div_valid ? w_res : '0;
endmodule
